// File: rtl/demux_scan_seq.sv
// demux_scan_seq
//   Sweep sequencer for a 1-to-8 demultiplexer. An accepted START latches the
//   A/B data pattern, then S steps through channels 0..7. On each channel E is
//   held high for DWELL cycles, and E is held low for GAP cycles between
//   channels. BUSY is high outside IDLE. DONE pulses for one cycle when the
//   sweep completes.
//
//   Optional feature: define DEMUX_SEQ_LOOP_EN to make the sweep wrap 7->0
//   and repeat until STOP or RST. In that mode DONE pulses once per lap.
//
// Parameters
//   DWELL : cycles E stays high per channel (1..255)
//   GAP   : cycles E stays low between channels (0..255)
// Ports
//   CLK        : clock, rising edge
//   RST        : synchronous active-high reset
//   START      : sweep request (ignored while BUSY)
//   STOP       : abort request (priority over all other transitions)
//   A_IN, B_IN : data pattern, latched on an accepted START
//   E, A, B, S : registered demux enable / data / channel select
//   BUSY       : high in every state except IDLE
//   DONE       : one-cycle completion pulse

module demux_scan_seq #(
   parameter int unsigned DWELL = 4,
   parameter int unsigned GAP   = 1
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       START,
   input  logic       STOP,
   input  logic       A_IN,
   input  logic       B_IN,
   output logic       E,
   output logic       A,
   output logic       B,
   output logic [2:0] S,
   output logic       BUSY,
   output logic       DONE
);

   typedef enum logic [1:0] {StIdle, StDrive, StGap, StDone} state_e;

   // With GAP = 0 this wraps to 255, but StGap is then never entered.
   localparam logic [7:0] DwellLast = 8'(DWELL - 1);
   localparam logic [7:0] GapLast   = 8'(GAP - 1);

   state_e     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic       e_d, a_d, b_d, busy_d, done_d;
   logic [2:0] s_d;
   logic       dwell_end, gap_end, last_ch, step_d;

   assign dwell_end = (cnt_q == DwellLast);
   assign gap_end   = (cnt_q == GapLast);
   assign last_ch   = (S == 3'd7);

   // DRIVE -> DRIVE channel step, only reachable with GAP = 0
   assign step_d    = (state_q == StDrive) && (state_d == StDrive) && dwell_end;

   // State and output registers
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= StIdle;
         cnt_q   <= 8'd0;
         E       <= 1'b0;
         A       <= 1'b0;
         B       <= 1'b0;
         S       <= 3'd0;
         BUSY    <= 1'b0;
         DONE    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         E       <= e_d;
         A       <= a_d;
         B       <= b_d;
         S       <= s_d;
         BUSY    <= busy_d;
         DONE    <= done_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (START && !STOP) state_d = StDrive;
         end
         StDrive: begin
            if (STOP) begin
               state_d = StIdle;
            end else if (dwell_end) begin
`ifdef DEMUX_SEQ_LOOP_EN
               state_d = (GAP != 0) ? StGap : StDrive;
`else
               if (last_ch) state_d = StDone;
               else         state_d = (GAP != 0) ? StGap : StDrive;
`endif
            end
         end
         StGap: begin
            if (STOP)         state_d = StIdle;
            else if (gap_end) state_d = StDrive;
         end
         StDone: begin
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Counter and registered-output next values
   always_comb begin
      // Counter restarts on every state entry, including a DRIVE->DRIVE step
      if (state_q == StIdle || state_d != state_q || step_d) cnt_d = 8'd0;
      else                                                   cnt_d = 8'(cnt_q + 8'd1);

      e_d    = (state_d == StDrive);
      busy_d = (state_d != StIdle);
      // Marks the end of the channel-7 dwell: completion (or one lap in loop mode)
      done_d = (state_q == StDrive) && !STOP && dwell_end && last_ch;

      s_d = S;
      a_d = A;
      b_d = B;
      if (state_d == StIdle || state_d == StDone) begin
         s_d = 3'd0;
         a_d = 1'b0;
         b_d = 1'b0;
      end else if (state_q == StIdle && state_d == StDrive) begin
         s_d = 3'd0;
         a_d = A_IN;
         b_d = B_IN;
      end else if (step_d || (state_q == StGap && state_d == StDrive)) begin
         s_d = S + 3'd1;
      end
   end

endmodule

// File: tb/tb_demux_scan_seq.sv
module tb_demux_scan_seq;

   logic clk = 1'b0;
   logic rst = 1'b1, start = 1'b0, stop = 1'b0, a_in = 1'b0, b_in = 1'b0;

   logic       e0, a0, b0, busy0, done0;
   logic [2:0] s0;
   logic       e1, a1, b1, busy1, done1;
   logic [2:0] s1;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   always #5 clk = ~clk;

   // Instance 0: default timing; instance 1: DWELL = 1, GAP = 0
   demux_scan_seq #(.DWELL(4), .GAP(1)) u_def (
      .CLK(clk), .RST(rst), .START(start), .STOP(stop), .A_IN(a_in), .B_IN(b_in),
      .E(e0), .A(a0), .B(b0), .S(s0), .BUSY(busy0), .DONE(done0)
   );

   demux_scan_seq #(.DWELL(1), .GAP(0)) u_zg (
      .CLK(clk), .RST(rst), .START(start), .STOP(stop), .A_IN(a_in), .B_IN(b_in),
      .E(e1), .A(a1), .B(b1), .S(s1), .BUSY(busy1), .DONE(done1)
   );

   // Reference model: per instance, whether a sweep is running, cycles since
   // the accepted START, and the latched data pattern.
   int dw[2] = '{4, 1};
   int gp[2] = '{1, 0};
   bit act[2];
   int tt[2];
   bit la[2];
   bit lb[2];

   // Expected {E,A,B,S,BUSY,DONE} from the sweep timing rules
   function automatic logic [7:0] exp_word(bit ac, int t, bit a, bit b, int d, int g);
      int p, k, r, tm;
      p = d + g;
      if (!ac) return 8'd0;
`ifdef DEMUX_SEQ_LOOP_EN
      tm = t % (8 * p);
      k  = tm / p;
      r  = tm % p;
      return {(r < d), a, b, 3'(k), 1'b1,
              (((t + g) % (8 * p)) == 0) && ((t + g) >= 8 * p)};
`else
      tm = 8 * d + 7 * g;
      if (t == tm) return 8'b000_000_11;
      k = t / p;
      r = t % p;
      return {(r < d), a, b, 3'(k), 1'b1, 1'b0};
`endif
   endfunction

   task automatic model_edge(input int i);
      if (rst) begin
         act[i] = 1'b0;
      end else if (act[i]) begin
         if (stop) begin
            act[i] = 1'b0;
         end else begin
            tt[i]++;
`ifndef DEMUX_SEQ_LOOP_EN
            if (tt[i] > 8 * dw[i] + 7 * gp[i]) act[i] = 1'b0;
`endif
         end
      end else if (start && !stop) begin
         act[i] = 1'b1;
         tt[i]  = 0;
         la[i]  = a_in;
         lb[i]  = b_in;
      end
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s cyc%0d observed {E,A,B,S,BUSY,DONE}=%b expected %b",
                tag, cyc, obs, exp);
      end
   endtask

   task automatic step(input bit r, input bit st, input bit sp, input bit ai, input bit bi);
      rst   = r;
      start = st;
      stop  = sp;
      a_in  = ai;
      b_in  = bi;
      @(posedge clk);
      cyc++;
      model_edge(0);
      model_edge(1);
      #1;
      chk("def", {e0, a0, b0, s0, busy0, done0},
          exp_word(act[0], tt[0], la[0], lb[0], dw[0], gp[0]));
      chk("zg", {e1, a1, b1, s1, busy1, done1},
          exp_word(act[1], tt[1], la[1], lb[1], dw[1], gp[1]));
   endtask

   initial begin
      // Reset held with START high
      step(1, 1, 0, 1, 1);
      step(1, 1, 0, 1, 1);
      // Full sweep, A=1 B=0 (zero-gap instance sweeps concurrently)
      step(0, 1, 0, 1, 0);
      for (int i = 0; i < 44; i++) step(0, 0, 0, 0, 0);
      // Zero-gap pattern A=0 B=1
      step(0, 1, 0, 0, 1);
      for (int i = 0; i < 12; i++) step(0, 0, 0, 1, 0);
      // Abort while default instance drives channel 3
      step(0, 1, 0, 1, 1);
      for (int i = 0; i < 16; i++) step(0, 0, 0, 0, 0);
      step(0, 0, 1, 0, 0);
      for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0);
      // START with STOP in IDLE is not accepted
      step(0, 1, 1, 1, 1);
      step(0, 0, 0, 0, 0);
      // Ignored re-START mid-sweep with a different pattern
      step(0, 1, 0, 1, 1);
      for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      for (int i = 0; i < 34; i++) step(0, 0, 0, 0, 0);
      // START held: back-to-back sweeps
      for (int i = 0; i < 100; i++) step(0, 1, 0, 0, 1);
      // Reset mid-sweep with START and STOP high
      step(0, 0, 0, 0, 0);
      for (int i = 0; i < 8; i++) step(0, 0, 0, 0, 0);
      step(1, 1, 1, 1, 1);
      step(0, 0, 0, 0, 0);
      // Randomized traffic
      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 99) == 0, $urandom_range(0, 7) == 0,
              $urandom_range(0, 39) == 0, 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/demux_scan_seq.md
# demux_scan_seq

Sweep sequencer placed directly upstream of the 1-to-8 demultiplexer (`E`, `A`, `B`, `S[2:0]` → `D[7:0]`). On a start request it latches a data pattern and drives the demux enable, data and select lines. It steps `S` through channels 0..7 with a programmable dwell per channel and an enable-low gap between channels. It reports busy and sweep completion to the controlling logic.

## Interface
Parameters:
- `DWELL`, default 4: cycles `E` stays high per channel; legal range 1..255.
- `GAP`, default 1: cycles `E` stays low between consecutive channels; legal range 0..255.

Ports:
- `CLK` in 1: single clock; all logic is rising-edge.
- `RST` in 1: reset, synchronous and active-high.
- `START` in 1: sweep request, sampled at each edge.
- `STOP` in 1: abort request, sampled at each edge.
- `A_IN` in 1: data-A value, latched at accepted `START`.
- `B_IN` in 1: data-B value, latched at accepted `START`.
- `E` out 1: demux enable.
- `A` out 1: demux data A.
- `B` out 1: demux data B.
- `S` out 3: demux channel select.
- `BUSY` out 1: high in every state except IDLE.
- `DONE` out 1: one-cycle pulse at sweep completion.

## Operation
All outputs are registered.

Reset values: `E`=0, `A`=0, `B`=0, `S`=0, `BUSY`=0, `DONE`=0. The FSM resets to IDLE and the dwell/gap counter resets to 0.

States:
- **IDLE**: `E`=0, `S`=0, `BUSY`=0.
  - `START`=1 and `STOP`=0 → latch `A_IN`/`B_IN` into `A`/`B` and go to DRIVE with `S`=0.
- **DRIVE**: `E`=1, `A`/`B` hold their latched values, `S` holds the current channel.
  - After `DWELL` cycles with `S`=7 → DONE.
  - After `DWELL` cycles with `S`<7 and `GAP`>0 → GAP.
  - After `DWELL` cycles with `S`<7 and `GAP`=0 → stay in DRIVE with `S`+1 (no `E` drop).
- **GAP**: `E`=0; `S`, `A` and `B` hold.
  - After `GAP` cycles → DRIVE with `S`+1.
- **DONE**: `E`=0, `DONE`=1 for exactly one cycle, `S` returns to 0, `A`/`B` clear to 0.
  - Next cycle → IDLE.

Rules:
- `STOP`=1 in any non-IDLE state → IDLE on the next edge, with all outputs at reset values. `DONE` is not pulsed. `STOP` has priority over every other transition.
- `START` while `BUSY`=1 is ignored; the latched `A`/`B` values do not change.
- `START` and `STOP` high together in IDLE → stay in IDLE.
- `RST` mid-sweep → reset values on the next edge, regardless of `START`/`STOP`.
- `S` increments modulo 8. Without the loop option, `S` never wraps inside a sweep.
- The counter counts 0..N-1 and clears on every state entry.

## Timing
- Accepted `START` at edge n: `E`=1, `S`=0, `BUSY`=1 visible after edge n.
- Channel k (0-based) drive window: `E` high from edge n+1+k·(`DWELL`+`GAP`) for `DWELL` cycles.
- With the default parameters (4, 1): `S`=0 at edges n+1..n+4, gap at n+5, `S`=1 at n+6..n+9, …, `S`=7 at n+36..n+39. `DONE`=1 at n+40, and `BUSY`=0 from n+41.
- Total sweep length: 8·`DWELL` + 7·`GAP` + 1 cycles, then IDLE.
- A new `START` is accepted earliest in the first IDLE cycle. It may be held high continuously; back-to-back sweeps then have exactly one IDLE cycle between them.
- `S` changes only while `E`=0, or on a DRIVE→DRIVE step when `GAP`=0.

## Configuration
- `DEMUX_SEQ_LOOP_EN` defined:
  - After the channel-7 dwell, the FSM goes to GAP (or straight to DRIVE if `GAP`=0) with `S` wrapping to 0, and keeps sweeping until `STOP` or `RST`.
  - `DONE` pulses for one cycle on the first cycle after each channel-7 dwell ends.
  - The DONE state is unused.
  - `BUSY` stays high throughout.
- Not defined: single sweep exactly as described in Operation.

## Test plan
- **Reset:** `RST`=1 for 2 cycles with `START`=1 → all outputs 0, `BUSY`=0; after release `START` is accepted and `E`=1, `S`=0 on the next edge.
- **Full sweep, defaults:** `A_IN`=1, `B_IN`=0, `START` pulsed at edge n → `S` steps 0..7 with 4-cycle `E` windows and 1-cycle gaps. `A`=1 and `B`=0 throughout. `DONE`=1 only at n+40; back in IDLE at n+41.
- **Zero gap:** `GAP`=0, `DWELL`=1, `A_IN`=0, `B_IN`=1 → `E` stays high for 8 consecutive cycles while `S`=0..7. `DONE` in the 9th cycle.
- **Abort:** `STOP` asserted while `S`=3 in DRIVE → next edge `E`=0, `S`=0, `BUSY`=0, and `DONE` never asserts.
- **Ignored start:** `START` re-pulsed mid-sweep with different `A_IN`/`B_IN` → sweep timing and latched `A`/`B` are unchanged.
- **Loop mode (`DEMUX_SEQ_LOOP_EN`):** `START` at n with defaults → `S` wraps 7→0 without leaving BUSY. `DONE` pulses at n+40 and n+80, and `STOP` ends the sweep.
